// File: rtl/lcd_hd44780_driver.sv
// rtl/lcd_hd44780_driver.sv - HD44780 init sequence and continuous two-line refresh from a 32x8 character RAM
module lcd_hd44780_driver #(
  parameter int PWR_WAIT  = 750000,
  parameter int EN_CYCLES = 25,
  parameter int CMD_WAIT  = 2500,
  parameter int CLR_WAIT  = 100000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic [4:0] o_ram_raddr,
  input  logic [7:0] i_ram_dout,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic       o_lcd_on,
  output logic       o_lcd_blon,
  output logic       o_frame_done
);

  localparam int MAX_A = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
  localparam int MAX_B = (CMD_WAIT > EN_CYCLES) ? CMD_WAIT : EN_CYCLES;
  localparam int MAXV  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAXV + 1);

  typedef enum logic [2:0] {S_PWRUP, S_SETUP, S_EN_HI, S_HOLD, S_WAIT} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_init;
  logic [1:0]    r_init_idx;
  logic          r_line_cmd;
  logic [4:0]    r_idx;
  logic [7:0]    r_data;
  logic          r_rs;
  logic          r_en;
  logic          r_is_clr;
  logic          r_last_char;
  logic          r_frame_done;

  logic [CW-1:0] w_wait_lim;
  logic [CW:0]   w_cnt_p2;
  logic [7:0]    w_init_byte;
  logic [7:0]    w_next_byte;
  logic          w_next_rs;
  logic          w_start;

  always_comb begin
    w_wait_lim = r_is_clr ? CW'(CLR_WAIT) : CW'(CMD_WAIT);
    w_cnt_p2   = (CW+1)'(r_cnt) + (CW+1)'(2);
    case (r_init_idx)
      2'd0:    w_init_byte = 8'h38;
      2'd1:    w_init_byte = 8'h0C;
      2'd2:    w_init_byte = 8'h01;
      default: w_init_byte = 8'h06;
    endcase
    w_next_rs = 1'b0;
    if (r_init) begin
      w_next_byte = w_init_byte;
    end else if (r_line_cmd) begin
      w_next_byte = r_idx[4] ? 8'hC0 : 8'h80;
    end else begin
      w_next_byte = i_ram_dout;
      w_next_rs   = 1'b1;
    end
    w_start = ((r_state == S_PWRUP) && (r_cnt == CW'(PWR_WAIT - 1))) ||
              ((r_state == S_WAIT)  && (r_cnt == w_wait_lim - CW'(1)));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_PWRUP;
      r_cnt        <= '0;
      r_init       <= 1'b1;
      r_init_idx   <= 2'd0;
      r_line_cmd   <= 1'b0;
      r_idx        <= 5'd0;
      r_data       <= 8'h00;
      r_rs         <= 1'b0;
      r_en         <= 1'b0;
      r_is_clr     <= 1'b0;
      r_last_char  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      // The byte is latched here so later RAM writes cannot disturb an in-flight transaction.
      if (w_start) begin
        r_state     <= S_SETUP;
        r_cnt       <= '0;
        r_data      <= w_next_byte;
        r_rs        <= w_next_rs;
        r_is_clr    <= r_init && (r_init_idx == 2'd2);
        r_last_char <= !r_init && !r_line_cmd && (r_idx == 5'd31);
      end else begin
        case (r_state)
          S_PWRUP: r_cnt <= r_cnt + CW'(1);
          S_SETUP: begin
            r_en    <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_EN_HI;
          end
          S_EN_HI: begin
            if (r_cnt == CW'(EN_CYCLES - 1)) begin
              r_en    <= 1'b0;
              r_cnt   <= '0;
              r_state <= S_HOLD;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_HOLD: begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
            if (r_last_char && (w_wait_lim == CW'(1))) r_frame_done <= 1'b1;
            // Advance to the next transaction; r_idx doubles as the RAM read address.
            if (r_init) begin
              if (r_init_idx == 2'd3) begin
                r_init     <= 1'b0;
                r_line_cmd <= 1'b1;
              end else begin
                r_init_idx <= r_init_idx + 2'd1;
              end
            end else if (r_line_cmd) begin
              r_line_cmd <= 1'b0;
            end else begin
              r_idx      <= r_idx + 5'd1;
              r_line_cmd <= (r_idx[3:0] == 4'hF);
            end
          end
          S_WAIT: begin
            r_cnt <= r_cnt + CW'(1);
            if (r_last_char && (w_cnt_p2 == (CW+1)'(w_wait_lim))) r_frame_done <= 1'b1;
          end
          default: r_state <= S_PWRUP;
        endcase
      end
    end
  end

  assign o_ram_raddr  = r_idx;
  assign o_lcd_data   = r_data;
  assign o_lcd_rs     = r_rs;
  assign o_lcd_rw     = 1'b0;
  assign o_lcd_en     = r_en;
  assign o_lcd_on     = 1'b1;
  assign o_lcd_blon   = 1'b1;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// tb/tb_lcd_hd44780_driver.sv - scoreboard bench for lcd_hd44780_driver with a cycle-arithmetic reference model
module tb_lcd_hd44780_driver;

  localparam int PWR_WAIT  = 20;
  localparam int EN_CYCLES = 4;
  localparam int CMD_WAIT  = 8;
  localparam int CLR_WAIT  = 30;
  localparam int DUR_NORM  = 2 + EN_CYCLES + CMD_WAIT;
  localparam int DUR_CLR   = 2 + EN_CYCLES + CLR_WAIT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ram_raddr;
  logic [7:0] ram_dout;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, frame_done;

  logic [7:0] ram [32];
  logic [7:0] model_ram [32];

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [4:0] addr;
    int         setup;
  } txn_t;

  txn_t exp_q [$];
  int   fd_q  [$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   next_setup;

  always #5 clk = ~clk;

  assign ram_dout = ram[ram_raddr];

  lcd_hd44780_driver #(
    .PWR_WAIT(PWR_WAIT), .EN_CYCLES(EN_CYCLES), .CMD_WAIT(CMD_WAIT), .CLR_WAIT(CLR_WAIT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_ram_raddr(ram_raddr), .i_ram_dout(ram_dout),
    .o_lcd_data(lcd_data), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw), .o_lcd_en(lcd_en),
    .o_lcd_on(lcd_on), .o_lcd_blon(lcd_blon), .o_frame_done(frame_done)
  );

  // cyc is the index of the current cycle, counted from the cycle right after reset release.
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic push_txn(input logic rs, input logic [7:0] d, input logic [4:0] a,
                          input int dur, input bit last);
    txn_t t;
    t.rs = rs; t.data = d; t.addr = a; t.setup = next_setup;
    exp_q.push_back(t);
    if (last) fd_q.push_back(next_setup + dur - 1);
    next_setup += dur;
  endtask

  task automatic push_init();
    push_txn(1'b0, 8'h38, 5'd0, DUR_NORM, 1'b0);
    push_txn(1'b0, 8'h0C, 5'd0, DUR_NORM, 1'b0);
    push_txn(1'b0, 8'h01, 5'd0, DUR_CLR,  1'b0);
    push_txn(1'b0, 8'h06, 5'd0, DUR_NORM, 1'b0);
  endtask

  task automatic push_frame();
    for (int p = 0; p < 32; p++) begin
      if (p == 0)  push_txn(1'b0, 8'h80, 5'd0,  DUR_NORM, 1'b0);
      if (p == 16) push_txn(1'b0, 8'hC0, 5'd16, DUR_NORM, 1'b0);
      push_txn(1'b1, model_ram[p], 5'(p), DUR_NORM, p == 31);
    end
  endtask

  // A write reaches every pending transaction for that position whose SETUP edge is still ahead.
  task automatic ram_write(input int p, input logic [7:0] v);
    ram[p] = v;
    model_ram[p] = v;
    foreach (exp_q[i])
      if (exp_q[i].rs && exp_q[i].addr == 5'(p) && exp_q[i].setup > cyc) exp_q[i].data = v;
  endtask

  task automatic wait_fd(input int bound, input bit rand_writes);
    bit seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
      else if (rand_writes && $urandom_range(0, 11) == 0)
        ram_write($urandom_range(0, 31), 8'($urandom_range(0, 255)));
    end
    if (!seen) fail_now("frame_done timeout");
  endtask

  task automatic check_reset_state();
    check("rst lcd_en", lcd_en, 0);
    check("rst lcd_rs", lcd_rs, 0);
    check("rst lcd_data", lcd_data, 0);
    check("rst ram_raddr", ram_raddr, 0);
    check("rst frame_done", frame_done, 0);
    check("rst lcd_rw", lcd_rw, 0);
    check("rst lcd_on", lcd_on, 1);
    check("rst lcd_blon", lcd_blon, 1);
  endtask

  // Monitor: one scoreboard pop per enable falling edge and per frame_done pulse.
  initial begin
    logic prev_en = 1'b0;
    int   rise_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_en = 1'b0;
      end else begin
        if (lcd_en && !prev_en) rise_cyc = cyc;
        if (!lcd_en && prev_en) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected transaction");
          end else begin
            txn_t e;
            e = exp_q.pop_front();
            check("byte rs+data", {lcd_rs, lcd_data}, {e.rs, e.data});
            check("setup cycle", rise_cyc - 1, e.setup);
            check("en width", cyc - rise_cyc, EN_CYCLES);
            check("ram_raddr", ram_raddr, e.addr);
          end
        end
        if (frame_done) begin
          if (fd_q.size() == 0) fail_now("unexpected frame_done");
          else check("frame_done cycle", cyc, fd_q.pop_front());
        end
        prev_en = lcd_en;
      end
    end
  end

  initial begin
    string s;
    bit    hit;
    s = "Score:";
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ram[i] = (i < 6) ? s[i] : 8'h20;
      model_ram[i] = ram[i];
    end
    repeat (3) @(negedge clk);
    check_reset_state();

    rst_n = 1'b1;
    next_setup = PWR_WAIT;
    push_init();
    push_frame();
    wait_fd(2000, 1'b0);
    push_frame();

    // Overwrite position 7 while its own transaction has the enable high.
    hit = 1'b0;
    for (int k = 0; k < 600 && !hit; k++) begin
      @(negedge clk);
      if (lcd_en && lcd_rs && ram_raddr == 5'd7) hit = 1'b1;
    end
    if (!hit) fail_now("addr 7 EN_HI timeout");
    ram_write(7, 8'h58);
    wait_fd(600, 1'b0);
    push_frame();

    for (int f = 2; f < 5; f++) begin
      wait_fd(600, 1'b1);
      push_frame();
    end

    repeat ($urandom_range(20, 300)) @(negedge clk);
    hit = 1'b0;
    for (int k = 0; k < 600 && !hit; k++) begin
      if (lcd_en && lcd_rs) hit = 1'b1;
      else @(negedge clk);
    end
    if (!hit) fail_now("data EN_HI timeout");
    #1 rst_n = 1'b0;
    #1;
    check("async rst lcd_en", lcd_en, 0);
    check("async rst ram_raddr", ram_raddr, 0);
    exp_q.delete();
    fd_q.delete();
    repeat (4) @(negedge clk);
    check_reset_state();

    rst_n = 1'b1;
    next_setup = PWR_WAIT;
    push_init();
    push_frame();
    wait_fd(2000, 1'b0);
    hit = 1'b0;
    for (int k = 0; k < 50 && !hit; k++) begin
      if (exp_q.size() == 0 && fd_q.size() == 0) hit = 1'b1;
      else @(negedge clk);
    end
    if (!hit) fail_now("scoreboard drain timeout");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout");
    $fatal(1, "global timeout");
  end

endmodule
